// File: rtl/pulse_env_stream_if.sv
// Command/stream bundle between the pulse parameter stage, the envelope
// address generator and the DDS/mixer stage.
interface pulse_env_stream_if #(
    parameter int unsigned PHASE_WIDTH    = 14,
    parameter int unsigned FREQ_WIDTH     = 24,
    parameter int unsigned ENV_ADDR_WIDTH = 12,
    parameter int unsigned ENV_WORD_WIDTH = 24
);
    logic                      cstrobe;
    logic [ENV_WORD_WIDTH-1:0] env_word;
    logic [FREQ_WIDTH-1:0]     freq;
    logic [PHASE_WIDTH-1:0]    phase;
    logic [ENV_ADDR_WIDTH-1:0] env_addr;
    logic                      env_ren;
    logic                      out_valid;
    logic                      out_first;
    logic                      out_last;
    logic [FREQ_WIDTH-1:0]     out_freq;
    logic [PHASE_WIDTH-1:0]    out_phase;
    logic                      busy;
    logic                      preempt_flag;

    modport master (
        output cstrobe, env_word, freq, phase,
        input  env_addr, env_ren, out_valid, out_first, out_last,
               out_freq, out_phase, busy, preempt_flag
    );

    modport slave (
        input  cstrobe, env_word, freq, phase,
        output env_addr, env_ren, out_valid, out_first, out_last,
               out_freq, out_phase, busy, preempt_flag
    );
endinterface

// File: rtl/pulse_env_stream.sv
// Envelope address walker: issues one envelope address per clock per pulse and
// delays freq/phase/flags by the memory read latency to align with read data.
module pulse_env_stream #(
    parameter int unsigned PHASE_WIDTH    = 14,
    parameter int unsigned FREQ_WIDTH     = 24,
    parameter int unsigned ENV_ADDR_WIDTH = 12,
    parameter int unsigned ENV_LEN_WIDTH  = 12,
    parameter int unsigned ENV_WORD_WIDTH = 24,
    parameter int unsigned MEM_LATENCY    = 2
) (
    input  logic               clk,
    input  logic               reset,
    pulse_env_stream_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [ENV_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ENV_LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                      first_q, first_d;
    logic [FREQ_WIDTH-1:0]     freq_q, freq_d;
    logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
    logic                      preempt_q, preempt_d;

    logic [ENV_ADDR_WIDTH-1:0] start_in;
    logic [ENV_LEN_WIDTH-1:0]  len_in;
    logic                      len_zero;
    logic                      run;
    logic                      last_c;

    assign start_in = bus.env_word[ENV_WORD_WIDTH-1 -: ENV_ADDR_WIDTH];
    assign len_in   = bus.env_word[ENV_LEN_WIDTH-1:0];
    assign len_zero = (len_in == '0);
    assign run      = (state_q == RUN);
    // The address on the bus this cycle is final if the count is exhausted or a strobe cuts it short
    assign last_c   = run && ((rem_q == '0) || bus.cstrobe);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        first_d   = first_q;
        freq_d    = freq_q;
        phase_d   = phase_q;
        preempt_d = preempt_q;

        if (run && bus.cstrobe && ((rem_q != '0) || len_zero)) begin
            preempt_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.cstrobe && !len_zero) begin
                    state_d = RUN;
                    addr_d  = start_in;
                    rem_d   = len_in - ENV_LEN_WIDTH'(1);
                    first_d = 1'b1;
                    freq_d  = bus.freq;
                    phase_d = bus.phase;
                end
            end
            RUN: begin
                if (bus.cstrobe) begin
                    if (len_zero) begin
                        state_d = IDLE;
                        first_d = 1'b0;
                    end else begin
                        addr_d  = start_in;
                        rem_d   = len_in - ENV_LEN_WIDTH'(1);
                        first_d = 1'b1;
                        freq_d  = bus.freq;
                        phase_d = bus.phase;
                    end
                end else if (rem_q == '0) begin
                    state_d = IDLE;
                    first_d = 1'b0;
                end else begin
                    addr_d  = addr_q + ENV_ADDR_WIDTH'(1);
                    rem_d   = rem_q - ENV_LEN_WIDTH'(1);
                    first_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            freq_q    <= '0;
            phase_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            freq_q    <= freq_d;
            phase_q   <= phase_d;
            preempt_q <= preempt_d;
        end
    end

    // Alignment pipeline; freq/phase stages only load behind a valid entry so they hold between pulses
    logic [MEM_LATENCY-1:0] v_p, f_p, l_p;
    logic [FREQ_WIDTH-1:0]  fr_p [MEM_LATENCY];
    logic [PHASE_WIDTH-1:0] ph_p [MEM_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            v_p <= '0;
            f_p <= '0;
            l_p <= '0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                fr_p[i] <= '0;
                ph_p[i] <= '0;
            end
        end else begin
            v_p[0] <= run;
            f_p[0] <= run && first_q;
            l_p[0] <= last_c;
            if (run) begin
                fr_p[0] <= freq_q;
                ph_p[0] <= phase_q;
            end
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                v_p[i] <= v_p[i-1];
                f_p[i] <= f_p[i-1];
                l_p[i] <= l_p[i-1];
                if (v_p[i-1]) begin
                    fr_p[i] <= fr_p[i-1];
                    ph_p[i] <= ph_p[i-1];
                end
            end
        end
    end

    assign bus.env_addr     = addr_q;
    assign bus.env_ren      = run;
    assign bus.busy         = run;
    assign bus.preempt_flag = preempt_q;
    assign bus.out_valid    = v_p[MEM_LATENCY-1];
    assign bus.out_first    = f_p[MEM_LATENCY-1];
    assign bus.out_last     = l_p[MEM_LATENCY-1];
    assign bus.out_freq     = fr_p[MEM_LATENCY-1];
    assign bus.out_phase    = ph_p[MEM_LATENCY-1];
endmodule

// File: tb/tb_pulse_env_stream.sv
// Directed bench for pulse_env_stream: per-cycle vector table plus hand-written
// wrap, preemption and mid-pulse reset sequences.
module tb_pulse_env_stream;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pulse_env_stream_if #(.PHASE_WIDTH(14), .FREQ_WIDTH(24), .ENV_ADDR_WIDTH(12),
                          .ENV_WORD_WIDTH(24)) bus ();

    pulse_env_stream #(
        .PHASE_WIDTH(14), .FREQ_WIDTH(24), .ENV_ADDR_WIDTH(12),
        .ENV_LEN_WIDTH(12), .ENV_WORD_WIDTH(24), .MEM_LATENCY(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        cs;
        logic [23:0] word;
        logic [23:0] fr;
        logic [13:0] ph;
        logic [11:0] addr;
        logic        ren;
        logic        busy;
        logic        val;
        logic        first;
        logic        last;
        logic [23:0] ofr;
        logic [13:0] oph;
        logic        pre;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [23:0] w(input logic [11:0] a, input logic [11:0] l);
        return {a, l};
    endfunction

    task automatic add(input logic cs, input logic [23:0] word, input logic [23:0] fr,
                       input logic [13:0] ph, input logic [11:0] addr, input logic ren,
                       input logic busy, input logic val, input logic first, input logic last,
                       input logic [23:0] ofr, input logic [13:0] oph, input logic pre);
        vec_t v;
        v.cs = cs; v.word = word; v.fr = fr; v.ph = ph; v.addr = addr; v.ren = ren;
        v.busy = busy; v.val = val; v.first = first; v.last = last; v.ofr = ofr;
        v.oph = oph; v.pre = pre;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic cs, input logic [23:0] word, input logic [23:0] fr,
                        input logic [13:0] ph);
        bus.cstrobe  = cs;
        bus.env_word = word;
        bus.freq     = fr;
        bus.phase    = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 24'h0, 24'h0, 14'h0);
    endtask

    initial begin
        logic [11:0] wa  [7] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h001, 12'h001, 12'h001};
        logic        wr  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        wv  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        wf  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        wl  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] pa  [8] = '{12'h100, 12'h101, 12'h102, 12'h300, 12'h301, 12'h301, 12'h301, 12'h301};
        logic        pr  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        pv  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        pf  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        pl  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        pp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [23:0] pfr [8] = '{24'h0, 24'h0, 24'hABCDEF, 24'hABCDEF, 24'hABCDEF,
                                 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F};
        int          nval;

        // single pulse, zero-length word, back-to-back pulses
        add(1, w(12'h010, 12'd3), 24'h123456, 14'h0AB, 12'h010, 1, 1, 0, 0, 0, 24'h0, 14'h0, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h011, 1, 1, 0, 0, 0, 24'h0, 14'h0, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 1, 1, 1, 1, 0, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 0, 0, 1, 0, 0, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 0, 0, 1, 0, 1, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 0, 0, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(1, w(12'h020, 12'd0), 24'h0AAAAA, 14'h111, 12'h012, 0, 0, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 0, 0, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h012, 0, 0, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(1, w(12'h100, 12'd2), 24'h000111, 14'h001, 12'h100, 1, 1, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h101, 1, 1, 0, 0, 0, 24'h123456, 14'h0AB, 0);
        add(1, w(12'h200, 12'd2), 24'h000222, 14'h002, 12'h200, 1, 1, 1, 1, 0, 24'h000111, 14'h001, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h201, 1, 1, 1, 0, 1, 24'h000111, 14'h001, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h201, 0, 0, 1, 1, 0, 24'h000222, 14'h002, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h201, 0, 0, 1, 0, 1, 24'h000222, 14'h002, 0);
        add(0, 24'h0, 24'h0, 14'h0, 12'h201, 0, 0, 0, 0, 0, 24'h000222, 14'h002, 0);

        reset = 1'b1;
        idle();
        idle();
        chk("reset env_ren", 64'(bus.env_ren), 64'h0);
        chk("reset busy", 64'(bus.busy), 64'h0);
        chk("reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset env_addr", 64'(bus.env_addr), 64'h0);
        chk("reset out_freq", 64'(bus.out_freq), 64'h0);
        chk("reset preempt", 64'(bus.preempt_flag), 64'h0);
        reset = 1'b0;
        idle();

        foreach (vecs[i]) begin
            tick(vecs[i].cs, vecs[i].word, vecs[i].fr, vecs[i].ph);
            chk($sformatf("row%0d env_addr", i), 64'(bus.env_addr), 64'(vecs[i].addr));
            chk($sformatf("row%0d env_ren", i), 64'(bus.env_ren), 64'(vecs[i].ren));
            chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(vecs[i].busy));
            chk($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].val));
            chk($sformatf("row%0d out_first", i), 64'(bus.out_first), 64'(vecs[i].first));
            chk($sformatf("row%0d out_last", i), 64'(bus.out_last), 64'(vecs[i].last));
            chk($sformatf("row%0d out_freq", i), 64'(bus.out_freq), 64'(vecs[i].ofr));
            chk($sformatf("row%0d out_phase", i), 64'(bus.out_phase), 64'(vecs[i].oph));
            chk($sformatf("row%0d preempt", i), 64'(bus.preempt_flag), 64'(vecs[i].pre));
        end

        // address wrap at the top of the envelope memory
        for (int t = 0; t < 7; t++) begin
            if (t == 0) tick(1'b1, w(12'hFFE, 12'd4), 24'h00FFFF, 14'h3FFF);
            else idle();
            chk($sformatf("wrap t%0d env_addr", t), 64'(bus.env_addr), 64'(wa[t]));
            chk($sformatf("wrap t%0d env_ren", t), 64'(bus.env_ren), 64'(wr[t]));
            chk($sformatf("wrap t%0d out_valid", t), 64'(bus.out_valid), 64'(wv[t]));
            chk($sformatf("wrap t%0d out_first", t), 64'(bus.out_first), 64'(wf[t]));
            chk($sformatf("wrap t%0d out_last", t), 64'(bus.out_last), 64'(wl[t]));
            if (wv[t]) chk($sformatf("wrap t%0d out_phase", t), 64'(bus.out_phase), 64'h3FFF);
        end

        // preemption of an 8-long pulse by a 2-long pulse on its third address
        for (int t = 0; t < 8; t++) begin
            if (t == 0) tick(1'b1, w(12'h100, 12'd8), 24'hABCDEF, 14'h155);
            else if (t == 3) tick(1'b1, w(12'h300, 12'd2), 24'h0F0F0F, 14'h2AA);
            else idle();
            chk($sformatf("pre t%0d env_addr", t), 64'(bus.env_addr), 64'(pa[t]));
            chk($sformatf("pre t%0d env_ren", t), 64'(bus.env_ren), 64'(pr[t]));
            chk($sformatf("pre t%0d out_valid", t), 64'(bus.out_valid), 64'(pv[t]));
            chk($sformatf("pre t%0d out_first", t), 64'(bus.out_first), 64'(pf[t]));
            chk($sformatf("pre t%0d out_last", t), 64'(bus.out_last), 64'(pl[t]));
            chk($sformatf("pre t%0d preempt", t), 64'(bus.preempt_flag), 64'(pp[t]));
            if (pv[t]) chk($sformatf("pre t%0d out_freq", t), 64'(bus.out_freq), 64'(pfr[t]));
        end

        // reset in the middle of a pulse discards everything in flight
        tick(1'b1, w(12'h400, 12'd8), 24'h555555, 14'h0CC);
        idle();
        reset = 1'b1;
        idle();
        chk("midrst busy", 64'(bus.busy), 64'h0);
        chk("midrst env_ren", 64'(bus.env_ren), 64'h0);
        chk("midrst out_valid", 64'(bus.out_valid), 64'h0);
        chk("midrst env_addr", 64'(bus.env_addr), 64'h0);
        chk("midrst preempt", 64'(bus.preempt_flag), 64'h0);
        chk("midrst out_freq", 64'(bus.out_freq), 64'h0);
        reset = 1'b0;
        nval = 0;
        for (int t = 0; t < 8; t++) begin
            idle();
            if (bus.out_valid || bus.env_ren) nval++;
        end
        chk("midrst quiet after", 64'(nval), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
